// File: rtl/tile_out_scaler.sv
// tile_out_scaler
// Output stage behind the single-PE mesh tile. It takes the tile's signed
// accumulator value, applies a rounding arithmetic right shift and saturates
// the result to OUT_W signed bits. It also marks every ROWS-th result as the
// last of its group. Results go into a first-word-fall-through FIFO that is
// drained with a valid/ready handshake.
// The mesh cannot be stalled, so the input has no ready signal. A result
// that arrives when the FIFO is full is discarded and sets a sticky flag.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous reset, active low
//   io_in_c       signed accumulator value from the tile
//   io_in_valid   io_in_c / io_in_shift are valid this cycle
//   io_in_shift   unsigned right-shift amount
//   io_out_bits   scaled, saturated result at the FIFO head (0 when empty)
//   io_out_last   head entry closes a group of ROWS results
//   io_out_valid  FIFO holds at least one entry
//   io_out_ready  consumer takes the head entry this cycle
//   io_overflow   sticky: at least one result was dropped
//   io_sat_count  saturated results seen, holds at 0xFFFF
//   io_clear      synchronous clear of overflow, sat count and row counter
module tile_out_scaler #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4,
    parameter int ROWS  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic signed [IN_W-1:0] io_in_c,
    input  logic                   io_in_valid,
    input  logic [5:0]             io_in_shift,
    output logic [OUT_W-1:0]       io_out_bits,
    output logic                   io_out_last,
    output logic                   io_out_valid,
    input  logic                   io_out_ready,
    output logic                   io_overflow,
    output logic [15:0]            io_sat_count,
    input  logic                   io_clear
);

    localparam int SH_W  = $clog2(IN_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic signed [IN_W:0] SAT_MAX  = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W:0] SAT_MIN  = ~SAT_MAX;
    localparam logic signed [IN_W:0] WIDE_ONE = (IN_W+1)'(1);

    logic                   s1Valid_q;
    logic signed [IN_W-1:0] s1C_q;
    logic [5:0]             s1Shift_q;

    logic [SH_W-1:0]        shiftEff;
    logic signed [IN_W:0]   cWide;
    logic signed [IN_W:0]   bias;
    logic signed [IN_W:0]   sum;
    logic signed [IN_W:0]   rounded;
    logic                   satHi;
    logic                   satLo;
    logic [OUT_W-1:0]       resBits;
    logic                   resLast;

    logic [OUT_W-1:0]       memBits [DEPTH];
    logic                   memLast [DEPTH];
    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ROW_W-1:0]       rowCnt_q, rowCnt_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            satCount_q, satCount_d;

    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   drop;

    // The stage-1 register captures the tile output on every cycle. The
    // mesh does not wait, so this register has no enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1Valid_q <= 1'b0;
            s1C_q     <= '0;
            s1Shift_q <= '0;
        end else begin
            s1Valid_q <= io_in_valid;
            s1C_q     <= io_in_c;
            s1Shift_q <= io_in_shift;
        end
    end

    // Rounding shift and saturation. The math is one bit wider than the
    // input, so adding the half-LSB bias cannot wrap. When the shift is 0
    // the bias is zero and the value passes through unchanged.
    always_comb begin
        if (s1Shift_q > 6'(IN_W - 1)) begin
            shiftEff = SH_W'(IN_W - 1);
        end else begin
            shiftEff = s1Shift_q[SH_W-1:0];
        end
        cWide = {s1C_q[IN_W-1], s1C_q};
        bias  = '0;
        if (shiftEff != '0) begin
            bias = WIDE_ONE << (shiftEff - 1'b1);
        end
        sum     = cWide + bias;
        rounded = sum >>> shiftEff;
        satHi   = (rounded > SAT_MAX);
        satLo   = (rounded < SAT_MIN);
        if (satHi) begin
            resBits = SAT_MAX[OUT_W-1:0];
        end else if (satLo) begin
            resBits = SAT_MIN[OUT_W-1:0];
        end else begin
            resBits = rounded[OUT_W-1:0];
        end
        resLast = (rowCnt_q == ROW_W'(ROWS - 1));
    end

    // FIFO control and the bookkeeping counters. A full FIFO still accepts
    // a result when the head leaves in the same cycle. The row counter also
    // advances for dropped results, so the group tags stay aligned with the
    // mesh. A clear overrides any update in the same cycle.
    always_comb begin
        full = (count_q == CNT_W'(DEPTH));
        pop  = (count_q != '0) && io_out_ready;
        push = s1Valid_q && (!full || pop);
        drop = s1Valid_q && full && !pop;

        wrPtr_d    = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d    = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        rowCnt_d   = rowCnt_q;
        overflow_d = overflow_q;
        satCount_d = satCount_q;
        if (s1Valid_q) begin
            rowCnt_d = resLast ? '0 : rowCnt_q + ROW_W'(1);
            if ((satHi || satLo) && (satCount_q != 16'hFFFF)) begin
                satCount_d = satCount_q + 16'd1;
            end
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (io_clear) begin
            rowCnt_d   = '0;
            overflow_d = 1'b0;
            satCount_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            rowCnt_q   <= '0;
            overflow_q <= 1'b0;
            satCount_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            rowCnt_q   <= rowCnt_d;
            overflow_q <= overflow_d;
            satCount_q <= satCount_d;
        end
    end

    // The storage array has no reset. A stale entry never reaches the
    // outputs because the head is masked whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            memBits[wrPtr_q] <= resBits;
            memLast[wrPtr_q] <= resLast;
        end
    end

    assign io_out_valid = (count_q != '0);
    assign io_out_bits  = io_out_valid ? memBits[rdPtr_q] : '0;
    assign io_out_last  = io_out_valid ? memLast[rdPtr_q] : 1'b0;
    assign io_overflow  = overflow_q;
    assign io_sat_count = satCount_q;

endmodule

// File: tb/tb_tile_out_scaler.sv
// tb_tile_out_scaler
// Self-checking bench for tile_out_scaler. A behavioural model uses integer
// division and a queue to predict the FIFO contents, flags and counters. It
// is compared with the DUT after every clock edge and after reset is
// asserted. Directed vectors with hand-computed results also pin rounding,
// saturation, shift clamping, backpressure, row tagging and mid-stream reset.
module tb_tile_out_scaler;

    localparam int IN_W  = 19;
    localparam int OUT_W = 8;
    localparam int DEPTH = 4;
    localparam int ROWS  = 4;

    logic                   clock;
    logic                   reset;
    logic signed [IN_W-1:0] io_in_c;
    logic                   io_in_valid;
    logic [5:0]             io_in_shift;
    logic [OUT_W-1:0]       io_out_bits;
    logic                   io_out_last;
    logic                   io_out_valid;
    logic                   io_out_ready;
    logic                   io_overflow;
    logic [15:0]            io_sat_count;
    logic                   io_clear;

    int nCompared   = 0;
    int nMismatched = 0;

    tile_out_scaler #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .DEPTH(DEPTH),
        .ROWS (ROWS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_in_c     (io_in_c),
        .io_in_valid (io_in_valid),
        .io_in_shift (io_in_shift),
        .io_out_bits (io_out_bits),
        .io_out_last (io_out_last),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_overflow (io_overflow),
        .io_sat_count(io_sat_count),
        .io_clear    (io_clear)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compares one value and records the result in the shared counters.
    task automatic checkOutput(input string name, input longint act, input longint exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference scaling: floor((c + 2^(s-1)) / 2^s), then clip to the 8-bit
    // signed range.
    function automatic void scaleRef(input int c, input int sh,
                                     output logic [7:0] bits, output bit sat);
        int     s;
        longint d, num, q;
        s = (sh > IN_W - 1) ? IN_W - 1 : sh;
        if (s == 0) begin
            q = c;
        end else begin
            d   = longint'(1) << s;
            num = longint'(c) + d / 2;
            q   = num / d;
            if ((num % d) != 0 && num < 0) q = q - 1;
        end
        sat = (q > 127) || (q < -128);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        bits = 8'(q);
    endfunction

    // Behavioural model state
    logic [8:0] mQueue[$];
    bit         mPendValid = 0;
    int         mPendC     = 0;
    int         mPendS     = 0;
    bit         mOverflow  = 0;
    int         mSatCount  = 0;
    int         mRow       = 0;

    // Model step and compare, run after every clock edge and every reset
    // assertion.
    initial begin
        logic [7:0] b;
        bit         sat;
        bit         doPop;
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                mQueue.delete();
                mPendValid = 0;
                mOverflow  = 0;
                mSatCount  = 0;
                mRow       = 0;
            end else begin
                doPop = (mQueue.size() > 0) && io_out_ready;
                if (mPendValid) begin
                    scaleRef(mPendC, mPendS, b, sat);
                    if (mQueue.size() < DEPTH || doPop) begin
                        if (doPop) void'(mQueue.pop_front());
                        doPop = 0;
                        mQueue.push_back({(mRow == ROWS - 1), b});
                    end else begin
                        mOverflow = 1;
                    end
                    mRow = (mRow + 1) % ROWS;
                    if (sat && mSatCount < 65535) mSatCount++;
                end
                if (doPop) void'(mQueue.pop_front());
                if (io_clear) begin
                    mOverflow = 0;
                    mSatCount = 0;
                    mRow      = 0;
                end
                mPendValid = io_in_valid;
                mPendC     = int'(io_in_c);
                mPendS     = int'(io_in_shift);
            end
            #1;
            checkOutput("model valid", io_out_valid, mQueue.size() > 0);
            checkOutput("model bits", io_out_bits, (mQueue.size() > 0) ? mQueue[0][7:0] : 0);
            checkOutput("model last", io_out_last, (mQueue.size() > 0) ? mQueue[0][8] : 0);
            checkOutput("model overflow", io_overflow, mOverflow);
            checkOutput("model satcount", io_sat_count, mSatCount);
        end
    end

    // Drives one input beat at the next falling edge.
    task automatic applyStimulus(input int c, input int sh, input bit v);
        @(negedge clock);
        io_in_valid = v;
        io_in_c     = IN_W'(c);
        io_in_shift = 6'(sh);
    endtask

    // Sends one value into an empty FIFO with ready high. It checks that the
    // output is not valid after the capture edge and shows the result after
    // the write edge.
    task automatic roundTrip(input int c, input int sh, input logic [7:0] exp, input string name);
        applyStimulus(c, sh, 1);
        applyStimulus(0, 0, 0);
        checkOutput({name, " latency"}, io_out_valid, 0);
        @(posedge clock);
        #2;
        checkOutput({name, " valid"}, io_out_valid, 1);
        checkOutput(name, io_out_bits, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8:0] seen[$];
        logic [7:0] lastMask;

        reset        = 1'b0;
        io_in_c      = '0;
        io_in_valid  = 1'b0;
        io_in_shift  = '0;
        io_out_ready = 1'b1;
        io_clear     = 1'b0;

        #1;
        checkOutput("reset valid", io_out_valid, 0);
        checkOutput("reset bits", io_out_bits, 0);
        checkOutput("reset overflow", io_overflow, 0);
        checkOutput("reset satcount", io_sat_count, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Rounding and shift clamp
        roundTrip(300, 2, 8'h4B, "round 300>>2");
        roundTrip(5, 1, 8'h03, "round 5>>1");
        roundTrip(-6, 2, 8'hFF, "round -6>>2");
        roundTrip(-2, 2, 8'h00, "round -2>>2");
        roundTrip(262143, 40, 8'h01, "clamp shift40");
        roundTrip(262143, 18, 8'h01, "shift18");

        // Saturation and clear
        roundTrip(1000, 0, 8'h7F, "sat high");
        checkOutput("sat count 1", io_sat_count, 1);
        roundTrip(-1000, 0, 8'h80, "sat low");
        checkOutput("sat count 2", io_sat_count, 2);
        @(negedge clock);
        io_clear = 1'b1;
        @(negedge clock);
        io_clear = 1'b0;
        checkOutput("sat count cleared", io_sat_count, 0);

        // Backpressure: four results stay in the FIFO and two are dropped
        io_out_ready = 1'b0;
        for (int v = 1; v <= 6; v++) applyStimulus(v, 0, 1);
        applyStimulus(0, 0, 0);
        @(negedge clock);
        checkOutput("bp overflow", io_overflow, 1);
        checkOutput("bp valid held", io_out_valid, 1);
        io_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checkOutput("bp drain bits", io_out_bits, i);
            checkOutput("bp drain last", io_out_last, (i == 4));
            @(negedge clock);
        end
        checkOutput("bp drained empty", io_out_valid, 0);

        // The dropped results advanced the row counter to 2, so 8 closes the group
        applyStimulus(7, 0, 1);
        applyStimulus(8, 0, 1);
        applyStimulus(0, 0, 0);
        checkOutput("drop row bits 7", io_out_bits, 7);
        checkOutput("drop row last 7", io_out_last, 0);
        @(negedge clock);
        checkOutput("drop row bits 8", io_out_bits, 8);
        checkOutput("drop row last 8", io_out_last, 1);
        io_clear = 1'b1;
        @(negedge clock);
        io_clear = 1'b0;
        checkOutput("overflow cleared", io_overflow, 0);

        // Row tagging over 8 back-to-back results
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (io_out_valid) seen.push_back({io_out_last, io_out_bits});
            io_in_valid = (i < 8);
            io_in_c     = IN_W'(20 + i);
            io_in_shift = '0;
        end
        checkOutput("row count outputs", seen.size(), 8);
        lastMask = '0;
        for (int i = 0; i < 8 && i < seen.size(); i++) lastMask[i] = seen[i][8];
        checkOutput("row last mask", lastMask, 8'b1000_1000);
        if (seen.size() > 0) checkOutput("row first bits", seen[0][7:0], 20);

        // Reset with three entries buffered
        io_out_ready = 1'b0;
        for (int v = 30; v < 33; v++) applyStimulus(v, 0, 1);
        applyStimulus(0, 0, 0);
        @(negedge clock);
        checkOutput("pre-reset valid", io_out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid reset valid", io_out_valid, 0);
        checkOutput("mid reset bits", io_out_bits, 0);
        @(negedge clock);
        reset        = 1'b1;
        io_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("post reset empty", io_out_valid, 0);
        end

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
